// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings, default width, counter sizing.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SS_DEFAULT_N = 8;

    function automatic int ss_cnt_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: sub = A - B - Bin, Bout = borrow out.
module full_sub (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic sub,
    output logic Bout
);

    assign sub  = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor, LSB first, one bit per clock through a single full_sub.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int N = SS_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         busy,
`ifdef SERIAL_SUB_OVF_EN
    output logic         ovf,
`endif
    output logic         done
);

    // state | meaning
    // IDLE  | waiting for start, outputs hold last result
    // RUN   | one operand bit per cycle, N cycles
    // DONE  | result published, done pulse for one cycle

    localparam int CNT_W = ss_cnt_width(N);

    state_t           r_state;
    logic [N-1:0]     r_sa;
    logic [N-1:0]     r_sb;
    logic [N-2:0]     r_res;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;

    logic             w_sub;
    logic             w_bout;
    logic [N-1:0]     w_shift;

    full_sub u_full_sub (
        .A    (r_sa[0]),
        .B    (r_sb[0]),
        .Bin  (r_borrow),
        .sub  (w_sub),
        .Bout (w_bout)
    );

    // Only the upper N-1 result bits need storing; the newest bit comes straight from full_sub.
    assign w_shift = {w_sub, r_res};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            diff     <= '0;
            bout     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= b;
                        r_res    <= '0;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_res    <= w_shift[N-1:1];
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(N - 1)) begin
                        diff    <= w_shift;
                        bout    <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last step sa[0]/sb[0] are the captured operand sign bits.
                        ovf     <= (r_sa[0] != r_sb[0]) && (w_sub != r_sa[0]);
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed and randomized self-checking bench for serial_sub (N=8); ovf checks active with SERIAL_SUB_OVF_EN.
module tb_serial_sub;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
    logic       busy;
    logic       done;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int checks   = 0;
    int failures = 0;

    logic [7:0] prev_d;
    logic       prev_bo;

    serial_sub #(.N(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .diff  (diff),
        .bout  (bout),
        .busy  (busy),
`ifdef SERIAL_SUB_OVF_EN
        .ovf   (ovf),
`endif
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation with cycle-by-cycle checks; inj re-pulses start (a=FF,b=00) in RUN cycle 3.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb,
                          input logic [7:0] ed, input logic ebo, input logic eovf,
                          input bit inj);
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = ~va;
        b = ~vb;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("run_busy", busy, 1'b1);
            chk("run_done_low", done, 1'b0);
            chk("run_diff_hold", diff, prev_d);
            chk("run_bout_hold", bout, prev_bo);
            if (inj && c == 3) begin
                a = 8'hFF;
                b = 8'h00;
                start = 1'b1;
            end
            if (inj && c == 4) start = 1'b0;
        end
        @(negedge clk);
        chk("done_pulse", done, 1'b1);
        chk("done_busy_low", busy, 1'b0);
        chk("diff", diff, ed);
        chk("bout", bout, ebo);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", ovf, eovf);
`else
        if (eovf === 1'bx) chk("ovf_arg", eovf, 1'b0);
`endif
        @(negedge clk);
        chk("idle_done_low", done, 1'b0);
        chk("idle_busy_low", busy, 1'b0);
        chk("idle_diff_hold", diff, ed);
        prev_d  = ed;
        prev_bo = ebo;
    endtask

    initial begin
        logic [7:0] ra, rb, rd;
        logic       rovf;
        int         k, ncyc, last_done, seen, ndone;

        rst = 1'b1;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        prev_d = 8'h00;
        prev_bo = 1'b0;
        #3;
        chk("rst_diff", diff, 8'h00);
        chk("rst_bout", bout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b1);

        // Reset in RUN cycle 4 aborts the operation.
        @(negedge clk);
        a = 8'h55;
        b = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_diff", diff, 8'h00);
        chk("abort_bout", bout, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_idle_busy", busy, 1'b0);
        prev_d = 8'h00;
        prev_bo = 1'b0;
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);

        // Back-to-back with start held high; operands scrambled once each op is underway.
        ncyc = 0;
        last_done = 0;
        for (int i = 0; i < 100; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rd = ra - rb;
            rovf = (ra[7] != rb[7]) && (rd[7] != ra[7]);
            a = ra;
            b = rb;
            start = 1'b1;
            k = 0;
            seen = 0;
            while (k < 20 && seen == 0) begin
                @(negedge clk);
                k++;
                ncyc++;
                if (k == 2) begin
                    a = 8'($urandom_range(0, 255));
                    b = 8'($urandom_range(0, 255));
                end
                if (done) seen = 1;
            end
            chk("rand_done_seen", seen, 1);
            if (seen == 0) break;
            chk("rand_diff", diff, rd);
            chk("rand_bout", bout, (ra < rb));
`ifdef SERIAL_SUB_OVF_EN
            chk("rand_ovf", ovf, rovf);
`else
            if (rovf === 1'bx) chk("rand_ovf_arg", rovf, 1'b0);
`endif
            if (i > 0) chk("rand_spacing", ncyc - last_done, 10);
            last_done = ncyc;
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, N, minuend; captured on the accepting edge.
REQ-006 The block SHALL have port b, input, N, subtrahend; captured on the accepting edge.
REQ-007 The block SHALL have port diff, output, N, registered result a-b (mod 2^N).
REQ-008 The block SHALL have port bout, output, 1, registered final borrow; 1 iff a<b unsigned.
REQ-009 The block SHALL have port busy, output, 1, high while in RUN.
REQ-010 The block SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, DONE, with IDLE as the reset state.
REQ-012 In IDLE with start=1 at a clock edge, the block SHALL:
  - load shift registers sa<=a, sb<=b;
  - clear the borrow flop and bit counter cnt;
  - enter RUN.
REQ-013 Each RUN edge SHALL:
  - feed sa[0], sb[0] and the borrow flop into one full_sub instance;
  - shift sa and sb right by 1;
  - shift the sub bit into the result register MSB;
  - load the borrow flop with Bout;
  - increment cnt.
REQ-014 On the RUN edge where cnt==N-1, the block SHALL enter DONE and update diff and bout with the final values.
REQ-015 The block SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE on the next edge.
REQ-016 Latency SHALL be fixed: done is high in the cycle beginning N+1 edges after the accepting edge (9 cycles for N=8).
REQ-017 diff and bout SHALL hold their values from DONE until the next accepted start; they SHALL NOT show partial results while busy.
REQ-018 start asserted in RUN or DONE SHALL be ignored; it is not queued.
REQ-019 Changes on a and b after the accepting edge SHALL have no effect on the operation in progress.
REQ-020 start held high continuously SHALL launch back-to-back operations: one per N+2 cycles, with IDLE lasting one cycle between them.
REQ-021 Borrow propagation SHALL be unsigned two's-complement. Boundary results:
  - 0-0 = 0 with bout=0;
  - 0-1 = all ones with bout=1;
  - (2^N-1)-(2^N-1) = 0 with bout=0.

Reset
REQ-022 While rst=1, the block SHALL immediately (asynchronously) force:
  - state=IDLE;
  - diff=0, bout=0, busy=0, done=0, ovf=0;
  - cnt, shift registers and borrow flop cleared.
REQ-023 Reset during RUN or DONE SHALL abort the operation with no done pulse. The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-024 With macro SERIAL_SUB_OVF_EN defined, the block SHALL add output port ovf (1 bit, registered, updated in DONE alongside diff).
  - ovf = signed overflow = (a[N-1]!=b[N-1]) && (diff[N-1]!=a[N-1]), using the captured operands.
REQ-025 Without SERIAL_SUB_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 A shared header SHALL hold:
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default width constant (8);
  - the counter-width rule ($clog2(N)).
REQ-027 The block SHALL instantiate the existing full_sub module (ports A, B, Bin, sub, Bout) as its single sub-module. No other sub-modules SHALL be used.

Verification
REQ-028 N=8, a=0x05, b=0x03, start pulse -> busy for 8 cycles, done in cycle 9, diff=0x02, bout=0.
REQ-029 a=0x03, b=0x05 -> diff=0xFE, bout=1. With SERIAL_SUB_OVF_EN: ovf=0.
REQ-030 With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, bout=1, ovf=1.
REQ-031 start re-pulsed at RUN cycle 3 with a=0xFF, b=0x00 -> ignored; the first operation's result is unchanged and exactly one done is seen.
REQ-032 rst pulsed at RUN cycle 4 -> all outputs 0 immediately and no done. Then a=0xFF, b=0xFF -> diff=0x00, bout=0 after 9 cycles.
REQ-033 Randomized: 100 random (a,b) pairs in back-to-back starts -> each diff == (a-b) mod 256, bout == (a<b), and done spacing is exactly 10 cycles.
